// File: rtl/led_seq_ctrl_pkg.sv
// Shared encodings for the LED sequencer: register map, modes, FSM states, CTRL fields,
// plus the one-step pattern update used by both RUN and single-step.
package led_seq_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PERIOD  = 2'd1;
    localparam logic [1:0] ADDR_PATTERN = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam logic [1:0] MODE_LEFT   = 2'b00;
    localparam logic [1:0] MODE_RIGHT  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_BLINK  = 2'b11;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_STEP    = 3;

    localparam logic [8:0] HB_TICKS = 9'd500;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Returns {dir, pattern} after one advance; dir 1 = moving right.
    function automatic logic [4:0] advance_pat(input logic [1:0] mode,
                                               input logic [3:0] p,
                                               input logic dir);
        logic [3:0] rl, rr;
        logic [4:0] res;
        rl = {p[2:0], p[3]};
        rr = {p[0], p[3:1]};
        case (mode)
            MODE_LEFT:  res = {dir, rl};
            MODE_RIGHT: res = {dir, rr};
            MODE_BLINK: res = {dir, ~p};
            default: begin
                if (!dir && p[3])     res = {1'b1, rr};
                else if (dir && p[0]) res = {1'b0, rl};
                else                  res = {dir, dir ? rr : rl};
            end
        endcase
        return res;
    endfunction

endpackage

// File: rtl/led_seq_ctrl_if.sv
// Register-bank write/read port plus LED outputs of the sequencer.
interface led_seq_ctrl_if;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] led_n;
    logic       hb;

    modport master (output wr_en, wr_addr, wr_data, rd_addr,
                    input  rd_data, led_n, hb);
    modport slave  (input  wr_en, wr_addr, wr_data, rd_addr,
                    output rd_data, led_n, hb);
endinterface

// File: rtl/led_seq_ctrl_tick.sv
// Prescaler + period counter; advance pulses once every max(period,1) base ticks.
module led_tick_gen #(
    parameter int TICK_DIV = 12000,
    parameter int PW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          clear,
    input  logic [PW-1:0] period,
    output logic          advance
);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DW-1:0] pcnt;
    logic [PW-1:0] qcnt;
    logic [PW-1:0] qlast;
    logic          tick;

    assign qlast   = (period == '0) ? '0 : period - PW'(1);
    assign tick    = run && (pcnt == DW'(TICK_DIV - 1));
    assign advance = tick && (qcnt == qlast);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
            qcnt <= '0;
        end else if (clear) begin
            pcnt <= '0;
            qcnt <= '0;
        end else if (run) begin
            pcnt <= tick ? '0 : pcnt + DW'(1);
            if (tick)
                qcnt <= (qcnt == qlast) ? '0 : qcnt + PW'(1);
        end
    end
endmodule

// File: rtl/led_seq_ctrl.sv
// Host-configurable 4-LED rotator: register bank, IDLE/LOAD/RUN sequencer, heartbeat.
module led_seq_ctrl
    import led_seq_ctrl_pkg::*;
#(
    parameter int         TICK_DIV   = 12000,
    parameter logic [7:0] PERIOD_RST = 8'd250,
    parameter logic [3:0] SEED_RST   = 4'b0001
) (
    input  logic          clk,
    input  logic          rst,
    led_seq_ctrl_if.slave bus
);
    state_t     state;
    logic       en;
    logic [1:0] mode;
    logic [7:0] period;
    logic [3:0] seed;
    logic [3:0] pattern;
    logic       dir;
    logic [7:0] rd_q;
    logic       hb_q;
    logic       adv, hb_adv;
    logic       wr_ctrl, wr_per, wr_pat, step_req;

    assign wr_ctrl  = bus.wr_en && (bus.wr_addr == ADDR_CTRL);
    assign wr_per   = bus.wr_en && (bus.wr_addr == ADDR_PERIOD);
    assign wr_pat   = bus.wr_en && (bus.wr_addr == ADDR_PATTERN);
    // A CTRL write that also sets enable takes the LOAD path; its step bit is dropped.
    assign step_req = wr_ctrl && bus.wr_data[CTRL_STEP] && !bus.wr_data[CTRL_EN];

    led_tick_gen #(.TICK_DIV(TICK_DIV), .PW(8)) u_step (
        .clk(clk), .rst(rst),
        .run(state == ST_RUN),
        .clear((state == ST_LOAD) || wr_per),
        .period(period),
        .advance(adv)
    );

    led_tick_gen #(.TICK_DIV(TICK_DIV), .PW(9)) u_hb (
        .clk(clk), .rst(rst),
        .run(1'b1), .clear(1'b0),
        .period(HB_TICKS),
        .advance(hb_adv)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            en      <= 1'b0;
            mode    <= MODE_LEFT;
            period  <= PERIOD_RST;
            seed    <= SEED_RST;
            pattern <= SEED_RST;
            dir     <= 1'b0;
            rd_q    <= '0;
            hb_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en   <= bus.wr_data[CTRL_EN];
                mode <= bus.wr_data[CTRL_MODE_LO +: 2];
            end
            if (wr_per) period <= bus.wr_data;
            if (wr_pat) seed <= bus.wr_data[3:0];

            // A seed write pre-empts everything, including a coincident advance.
            if (wr_pat) begin
                state <= ST_LOAD;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (en)
                            state <= ST_LOAD;
                        else if (step_req)
                            {dir, pattern} <= advance_pat(bus.wr_data[CTRL_MODE_LO +: 2], pattern, dir);
                    end
                    ST_LOAD: begin
                        pattern <= seed;
                        dir     <= 1'b0;
                        state   <= en ? ST_RUN : ST_IDLE;
                    end
                    ST_RUN: begin
                        if (!en)
                            state <= ST_IDLE;
                        else if (adv)
                            {dir, pattern} <= advance_pat(mode, pattern, dir);
                    end
                    default: state <= ST_IDLE;
                endcase
            end

            if (hb_adv) hb_q <= ~hb_q;

            case (bus.rd_addr)
                ADDR_CTRL:    rd_q <= {5'b0, mode, en};
                ADDR_PERIOD:  rd_q <= period;
                ADDR_PATTERN: rd_q <= {4'b0, seed};
                default:      rd_q <= {1'b0, state, dir, pattern};
            endcase
        end
    end

    assign bus.led_n   = ~pattern;
    assign bus.hb      = hb_q;
    assign bus.rd_data = rd_q;
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Scoreboard bench: stimulus queues expected LED patterns / read data; a negedge monitor checks them.
module tb_led_seq_ctrl;
    import led_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    led_seq_ctrl_if bus();

    led_seq_ctrl #(.TICK_DIV(4), .PERIOD_RST(8'd250), .SEED_RST(4'b0001)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [3:0] pat;
        int         gap;   // cycles since previous LED change, 0 = unchecked
    } led_exp_t;

    led_exp_t   led_q[$];
    logic [7:0] rd_q[$];
    led_exp_t   e;
    logic [7:0] er;
    int vectors = 0, miscompares = 0;
    int cyc = 0, last_chg = 0, nchg = 0, rel_cyc = 0;
    logic rd_chk = 1'b0, rd_chk_d = 1'b0;
    logic [3:0] prev_led = 4'b1110;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_chk_d <= rd_chk;
    end

    always @(negedge clk) begin
        if (rst) begin
            vectors++;
            if (bus.led_n !== 4'b1110 || bus.hb !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out: led_n=%b hb=%b, want led_n=1110 hb=0", bus.led_n, bus.hb);
            end
        end
        if (bus.led_n !== prev_led) begin
            prev_led = bus.led_n;
            nchg++;
            vectors++;
            if (led_q.size() == 0) begin
                miscompares++;
                $display("FAIL led_unexpected: led_n=%b at cycle %0d", bus.led_n, cyc);
            end else begin
                e = led_q.pop_front();
                if (bus.led_n !== ~e.pat || (e.gap != 0 && cyc - last_chg != e.gap)) begin
                    miscompares++;
                    $display("FAIL led_step: led_n=%b gap=%0d, want led_n=%b gap=%0d",
                             bus.led_n, cyc - last_chg, ~e.pat, e.gap);
                end
            end
            last_chg = cyc;
        end
        if (rd_chk_d) begin
            vectors++;
            if (rd_q.size() == 0) begin
                miscompares++;
                $display("FAIL rd_unexpected: rd_data=%h", bus.rd_data);
            end else begin
                er = rd_q.pop_front();
                if (bus.rd_data !== er) begin
                    miscompares++;
                    $display("FAIL rd_data: got %h want %h (cycle %0d)", bus.rd_data, er, cyc);
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] exp);
        bus.rd_addr = a;
        rd_q.push_back(exp);
        rd_chk = 1'b1;
        tick();
        rd_chk = 1'b0;
    endtask

    task automatic exp_led(input logic [3:0] p, input int g);
        led_exp_t x;
        x.pat = p; x.gap = g;
        led_q.push_back(x);
    endtask

    task automatic wait_chg(input int target, input string what);
        int n = 0;
        while (nchg < target && n < 200) begin
            tick();
            n++;
        end
        if (nchg < target) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout_%s: changes=%0d want %0d", what, nchg, target);
        end
    endtask

    initial begin
        int base, n0, n;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        #2 rst = 1'b1;
        tick();
        rd(ADDR_STATUS, 8'h00);
        rst = 1'b0;
        rel_cyc = cyc;
        rd(ADDR_STATUS, 8'h01);
        rd(ADDR_PERIOD, 8'hFA);
        rd(ADDR_PATTERN, 8'h01);
        rd(ADDR_CTRL, 8'h00);
        wr(ADDR_CTRL, 8'hF0);
        rd(ADDR_CTRL, 8'h00);
        wr(ADDR_STATUS, 8'hFF);
        rd(ADDR_STATUS, 8'h01);

        // rotate left, PERIOD=2 -> one step per 8 clk
        wr(ADDR_PERIOD, 8'd2);
        base = nchg;
        exp_led(4'b0010, 0); exp_led(4'b0100, 8); exp_led(4'b1000, 8);
        exp_led(4'b0001, 8); exp_led(4'b0010, 8);
        wr(ADDR_CTRL, 8'h01);
        wait_chg(base + 5, "rotate");

        // reset mid-run
        tick(2);
        exp_led(4'b0001, 0);
        rst = 1'b1;
        tick();
        rd(ADDR_STATUS, 8'h00);
        rst = 1'b0;
        rel_cyc = cyc;
        rd(ADDR_STATUS, 8'h01);

        // bounce
        wr(ADDR_PERIOD, 8'd2);
        base = nchg;
        exp_led(4'b0010, 0); exp_led(4'b0100, 8); exp_led(4'b1000, 8); exp_led(4'b0100, 8);
        exp_led(4'b0010, 8); exp_led(4'b0001, 8); exp_led(4'b0010, 8);
        wr(ADDR_CTRL, 8'h05);
        wait_chg(base + 4, "bounce_a");
        rd(ADDR_STATUS, 8'h54);
        wait_chg(base + 7, "bounce_b");
        rd(ADDR_STATUS, 8'h42);
        wr(ADDR_CTRL, 8'h00);
        tick();
        rd(ADDR_STATUS, 8'h02);

        // single step in IDLE
        base = nchg;
        exp_led(4'b0011, 0); exp_led(4'b0110, 0);
        wr(ADDR_PATTERN, 8'h03);
        tick(3);
        wr(ADDR_CTRL, 8'h08);
        wait_chg(base + 2, "step");
        tick(100);
        rd(ADDR_CTRL, 8'h00);
        rd(ADDR_PATTERN, 8'h03);
        rd(ADDR_STATUS, 8'h06);

        // PATTERN write colliding with an advance
        wr(ADDR_PERIOD, 8'd2);
        base = nchg;
        exp_led(4'b0011, 0); exp_led(4'b0110, 8);
        wr(ADDR_CTRL, 8'h01);
        wait_chg(base + 2, "coll_a");
        n0 = last_chg;
        exp_led(4'b1010, 9); exp_led(4'b0101, 8);
        while (cyc < n0 + 7) tick();
        wr(ADDR_PATTERN, 8'h0A);
        wait_chg(base + 4, "coll_b");
        wr(ADDR_CTRL, 8'h00);
        tick(2);

        // blink with PERIOD=0 (treated as 1)
        wr(ADDR_PERIOD, 8'd0);
        wr(ADDR_PATTERN, 8'h05);
        tick(3);
        base = nchg;
        exp_led(4'b1010, 0); exp_led(4'b0101, 4); exp_led(4'b1010, 4); exp_led(4'b0101, 4);
        wr(ADDR_CTRL, 8'h07);
        wait_chg(base + 4, "blink");
        wr(ADDR_CTRL, 8'h00);
        tick(2);
        rd(ADDR_PERIOD, 8'h00);
        rd(ADDR_PATTERN, 8'h05);
        rd(ADDR_STATUS, 8'h05);

        // heartbeat: first toggle 500 base ticks after reset release
        n = 0;
        while (bus.hb !== 1'b1 && n < 2500) begin
            tick();
            n++;
        end
        vectors++;
        if (bus.hb !== 1'b1 || cyc - rel_cyc != 2000) begin
            miscompares++;
            $display("FAIL hb_toggle: hb=%b after %0d cycles, want hb=1 after 2000", bus.hb, cyc - rel_cyc);
        end

        tick(5);
        vectors++;
        if (led_q.size() != 0 || rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover: led_q=%0d rd_q=%0d entries, want 0", led_q.size(), rd_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
